// File: rtl/execute_cc_stage_if.sv
// rtl/execute_cc_stage_if.sv - E-stage inputs and CC/M-register outputs of the execute CC stage
// Master drives the E-side operands and pipeline controls; slave returns CC, Cnd and the M register.
interface execute_cc_stage_if #(
  parameter int N = 64
);
  logic         e_valid;
  logic [3:0]   e_icode;
  logic [3:0]   e_ifun;
  logic [N-1:0] alu_x;
  logic [N-1:0] alu_y;
  logic [2:0]   alu_ctrl;
  logic [N-1:0] alu_result;
  logic [3:0]   e_dstE;
  logic         exc_in;
  logic         m_stall;
  logic         m_bubble;
  logic         cc_zf;
  logic         cc_sf;
  logic         cc_of;
  logic         e_cnd;
  logic         m_valid;
  logic [3:0]   m_icode;
  logic         m_cnd;
  logic [N-1:0] m_valE;
  logic [3:0]   m_dstE;

  modport master (
    output e_valid, e_icode, e_ifun, alu_x, alu_y, alu_ctrl, alu_result, e_dstE,
           exc_in, m_stall, m_bubble,
    input  cc_zf, cc_sf, cc_of, e_cnd, m_valid, m_icode, m_cnd, m_valE, m_dstE
  );

  modport slave (
    input  e_valid, e_icode, e_ifun, alu_x, alu_y, alu_ctrl, alu_result, e_dstE,
           exc_in, m_stall, m_bubble,
    output cc_zf, cc_sf, cc_of, e_cnd, m_valid, m_icode, m_cnd, m_valE, m_dstE
  );
endinterface

// File: rtl/execute_cc_stage.sv
// rtl/execute_cc_stage.sv - Y86-64 execute back end: flags, CC register, Cnd and E->M register
// Optional feature macro CC_CMOV_EN: squash the destination of a cmovXX whose condition fails.
module execute_cc_stage #(
  parameter int         N     = 64,
  parameter logic [3:0] RNONE = 4'hF
) (
  input logic                 clk,
  input logic                 rst_n,
  execute_cc_stage_if.slave   bus
);
  localparam logic [3:0] ICODE_NOP  = 4'h1;
  localparam logic [3:0] ICODE_CMOV = 4'h2;
  localparam logic [3:0] ICODE_OPQ  = 4'h6;

  logic zf_new;
  logic sf_new;
  logic of_new;
  logic set_cc;
  logic cnd;
  logic [3:0] dst_next;
  logic x_s;
  logic y_s;
  logic r_s;
  logic unused_operand_bits;

  assign x_s = bus.alu_x[N-1];
  assign y_s = bus.alu_y[N-1];
  assign r_s = bus.alu_result[N-1];
  // Only the sign bits of the operands matter for overflow detection.
  assign unused_operand_bits = ^{bus.alu_x[N-2:0], bus.alu_y[N-2:0]};

  always_comb begin
    zf_new = (bus.alu_result == '0);
    sf_new = r_s;
    of_new = 1'b0;
    case (bus.alu_ctrl)
      3'd0:    of_new = (x_s == y_s) && (r_s != x_s);
      3'd1:    of_new = (x_s != y_s) && (r_s != x_s);
      default: of_new = 1'b0;
    endcase
  end

  assign set_cc = bus.e_valid && (bus.e_icode == ICODE_OPQ) && !bus.exc_in && !bus.m_stall;

  always_comb begin
    cnd = 1'b0;
    case (bus.e_ifun)
      4'd0:    cnd = 1'b1;
      4'd1:    cnd = (bus.cc_sf ^ bus.cc_of) | bus.cc_zf;
      4'd2:    cnd = bus.cc_sf ^ bus.cc_of;
      4'd3:    cnd = bus.cc_zf;
      4'd4:    cnd = ~bus.cc_zf;
      4'd5:    cnd = ~(bus.cc_sf ^ bus.cc_of);
      4'd6:    cnd = ~(bus.cc_sf ^ bus.cc_of) & ~bus.cc_zf;
      default: cnd = 1'b0;
    endcase
  end

  assign bus.e_cnd = cnd;

`ifdef CC_CMOV_EN
  assign dst_next = ((bus.e_icode == ICODE_CMOV) && !cnd) ? RNONE : bus.e_dstE;
`else
  assign dst_next = bus.e_dstE;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.cc_zf   <= 1'b1;
      bus.cc_sf   <= 1'b0;
      bus.cc_of   <= 1'b0;
      bus.m_valid <= 1'b0;
      bus.m_icode <= ICODE_NOP;
      bus.m_cnd   <= 1'b0;
      bus.m_valE  <= '0;
      bus.m_dstE  <= RNONE;
    end else begin
      if (set_cc) begin
        bus.cc_zf <= zf_new;
        bus.cc_sf <= sf_new;
        bus.cc_of <= of_new;
      end
      // Stall dominates bubble; an empty E slot is treated exactly like a bubble.
      if (bus.m_stall) begin
        bus.m_valid <= bus.m_valid;
      end else if (bus.m_bubble || !bus.e_valid) begin
        bus.m_valid <= 1'b0;
        bus.m_icode <= ICODE_NOP;
        bus.m_cnd   <= 1'b0;
        bus.m_valE  <= '0;
        bus.m_dstE  <= RNONE;
      end else begin
        bus.m_valid <= 1'b1;
        bus.m_icode <= bus.e_icode;
        bus.m_cnd   <= cnd;
        bus.m_valE  <= bus.alu_result;
        bus.m_dstE  <= dst_next;
      end
    end
  end
endmodule

// File: tb/tb_execute_cc_stage.sv
// tb/tb_execute_cc_stage.sv - directed self-checking bench for execute_cc_stage
module tb_execute_cc_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int total = 0;
  int bad = 0;

  execute_cc_stage_if #(.N(64)) bus ();

  execute_cc_stage #(.N(64), .RNONE(4'hF)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] icode, input logic [3:0] ifun,
                       input logic [2:0] ctrl, input logic [63:0] x, input logic [63:0] y,
                       input logic [63:0] r, input logic [3:0] dst);
    bus.e_valid    = v;
    bus.e_icode    = icode;
    bus.e_ifun     = ifun;
    bus.alu_ctrl   = ctrl;
    bus.alu_x      = x;
    bus.alu_y      = y;
    bus.alu_result = r;
    bus.e_dstE     = dst;
    #1;
  endtask

  task automatic test_reset();
    bus.exc_in = 0; bus.m_stall = 0; bus.m_bubble = 0;
    drive(1, 4'h6, 4'h0, 3'd0, 64'd1, 64'd1, 64'd2, 4'h2);
    rst_n = 0;
    step();
    rst_n = 1;
    total++; if ({bus.cc_zf, bus.cc_sf, bus.cc_of} !== 3'b100) begin bad++; $display("FAIL reset_cc got %b exp 100", {bus.cc_zf, bus.cc_sf, bus.cc_of}); end
    total++; if (bus.m_icode !== 4'h1) begin bad++; $display("FAIL reset_icode got %h exp 1", bus.m_icode); end
    total++; if (bus.m_dstE !== 4'hF) begin bad++; $display("FAIL reset_dstE got %h exp f", bus.m_dstE); end
    total++; if (bus.m_valid !== 1'b0 || bus.m_cnd !== 1'b0) begin bad++; $display("FAIL reset_valid_cnd got %b%b exp 00", bus.m_valid, bus.m_cnd); end
    total++; if (bus.m_valE !== 64'd0) begin bad++; $display("FAIL reset_valE got %h exp 0", bus.m_valE); end
  endtask

  task automatic test_add_overflow();
    drive(1, 4'h6, 4'h0, 3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 4'h2);
    step();
    total++; if ({bus.cc_zf, bus.cc_sf, bus.cc_of} !== 3'b011) begin bad++; $display("FAIL add_ovf_cc got %b exp 011", {bus.cc_zf, bus.cc_sf, bus.cc_of}); end
    total++; if (bus.m_valE !== 64'h8000_0000_0000_0000 || bus.m_icode !== 4'h6 || bus.m_valid !== 1'b1 || bus.m_dstE !== 4'h2) begin
      bad++; $display("FAIL add_m_load got valE=%h icode=%h valid=%b dst=%h exp 8000000000000000 6 1 2", bus.m_valE, bus.m_icode, bus.m_valid, bus.m_dstE); end
    drive(1, 4'h7, 4'h2, 3'd0, 0, 0, 0, 4'hF);
    total++; if (bus.e_cnd !== 1'b0) begin bad++; $display("FAIL cnd_l got %b exp 0", bus.e_cnd); end
    drive(1, 4'h7, 4'h1, 3'd0, 0, 0, 0, 4'hF);
    total++; if (bus.e_cnd !== 1'b0) begin bad++; $display("FAIL cnd_le got %b exp 0", bus.e_cnd); end
    drive(1, 4'h7, 4'h5, 3'd0, 0, 0, 0, 4'hF);
    total++; if (bus.e_cnd !== 1'b1) begin bad++; $display("FAIL cnd_ge got %b exp 1", bus.e_cnd); end
    drive(1, 4'h7, 4'h0, 3'd0, 0, 0, 0, 4'hF);
    total++; if (bus.e_cnd !== 1'b1) begin bad++; $display("FAIL cnd_always got %b exp 1", bus.e_cnd); end
    drive(1, 4'h7, 4'h9, 3'd0, 0, 0, 0, 4'hF);
    total++; if (bus.e_cnd !== 1'b0) begin bad++; $display("FAIL cnd_undef got %b exp 0", bus.e_cnd); end
  endtask

  task automatic test_sub_flags();
    drive(1, 4'h6, 4'h1, 3'd1, 64'd5, 64'd5, 64'd0, 4'h3);
    step();
    total++; if ({bus.cc_zf, bus.cc_sf, bus.cc_of} !== 3'b100) begin bad++; $display("FAIL sub_zero_cc got %b exp 100", {bus.cc_zf, bus.cc_sf, bus.cc_of}); end
    drive(1, 4'h7, 4'h3, 3'd0, 0, 0, 0, 4'hF);
    step();
    total++; if (bus.m_cnd !== 1'b1 || bus.m_icode !== 4'h7) begin bad++; $display("FAIL jeq_m_cnd got %b icode %h exp 1 7", bus.m_cnd, bus.m_icode); end
    drive(1, 4'h7, 4'h4, 3'd0, 0, 0, 0, 4'hF);
    step();
    total++; if (bus.m_cnd !== 1'b0) begin bad++; $display("FAIL jne_m_cnd got %b exp 0", bus.m_cnd); end
    drive(1, 4'h6, 4'h1, 3'd1, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'h3);
    step();
    total++; if ({bus.cc_zf, bus.cc_sf, bus.cc_of} !== 3'b001) begin bad++; $display("FAIL sub_ovf_cc got %b exp 001", {bus.cc_zf, bus.cc_sf, bus.cc_of}); end
    drive(1, 4'h7, 4'h2, 3'd0, 0, 0, 0, 4'hF);
    total++; if (bus.e_cnd !== 1'b1) begin bad++; $display("FAIL cnd_l_ovf got %b exp 1", bus.e_cnd); end
    drive(1, 4'h7, 4'h6, 3'd0, 0, 0, 0, 4'hF);
    total++; if (bus.e_cnd !== 1'b0) begin bad++; $display("FAIL cnd_g_ovf got %b exp 0", bus.e_cnd); end
    drive(1, 4'h6, 4'h3, 3'd3, 64'd1, 64'd2, 64'h8000_0000_0000_0000, 4'h3);
    step();
    total++; if ({bus.cc_zf, bus.cc_sf, bus.cc_of} !== 3'b010) begin bad++; $display("FAIL xor_no_of got %b exp 010", {bus.cc_zf, bus.cc_sf, bus.cc_of}); end
    drive(1, 4'h6, 4'h0, 3'd5, 64'd1, 64'd2, 64'h8000_0000_0000_0001, 4'h3);
    step();
    total++; if ({bus.cc_zf, bus.cc_sf, bus.cc_of} !== 3'b010) begin bad++; $display("FAIL ctrl5_no_of got %b exp 010", {bus.cc_zf, bus.cc_sf, bus.cc_of}); end
  endtask

  task automatic test_exc_hold();
    bus.exc_in = 1;
    drive(1, 4'h6, 4'h0, 3'd0, 64'd0, 64'd0, 64'd0, 4'h4);
    step();
    bus.exc_in = 0;
    total++; if ({bus.cc_zf, bus.cc_sf, bus.cc_of} !== 3'b010) begin bad++; $display("FAIL exc_cc_hold got %b exp 010", {bus.cc_zf, bus.cc_sf, bus.cc_of}); end
    total++; if (bus.m_valE !== 64'd0 || bus.m_valid !== 1'b1 || bus.m_icode !== 4'h6) begin
      bad++; $display("FAIL exc_m_load got valE=%h valid=%b icode=%h exp 0 1 6", bus.m_valE, bus.m_valid, bus.m_icode); end
  endtask

  task automatic test_stall_bubble();
    drive(1, 4'h6, 4'h0, 3'd0, 64'd1, 64'd2, 64'd3, 4'h4);
    step();
    bus.m_stall = 1;
    drive(1, 4'h6, 4'h0, 3'd0, 64'd0, 64'd0, 64'd0, 4'h5);
    step();
    drive(1, 4'h2, 4'h0, 3'd0, 64'd0, 64'd0, 64'd9, 4'h6);
    step();
    total++; if (bus.m_valE !== 64'd3 || bus.m_dstE !== 4'h4 || bus.m_icode !== 4'h6 || bus.m_valid !== 1'b1) begin
      bad++; $display("FAIL stall_hold_m got valE=%h dst=%h icode=%h valid=%b exp 3 4 6 1", bus.m_valE, bus.m_dstE, bus.m_icode, bus.m_valid); end
    total++; if ({bus.cc_zf, bus.cc_sf, bus.cc_of} !== 3'b000) begin bad++; $display("FAIL stall_hold_cc got %b exp 000", {bus.cc_zf, bus.cc_sf, bus.cc_of}); end
    bus.m_bubble = 1;
    drive(1, 4'h6, 4'h0, 3'd0, 64'd0, 64'd0, 64'd0, 4'h5);
    step();
    total++; if (bus.m_valE !== 64'd3 || bus.m_icode !== 4'h6 || bus.cc_zf !== 1'b0) begin
      bad++; $display("FAIL stall_bubble_hold got valE=%h icode=%h zf=%b exp 3 6 0", bus.m_valE, bus.m_icode, bus.cc_zf); end
    bus.m_stall = 0;
    step();
    bus.m_bubble = 0;
    total++; if (bus.m_icode !== 4'h1 || bus.m_valid !== 1'b0 || bus.m_valE !== 64'd0 || bus.m_dstE !== 4'hF) begin
      bad++; $display("FAIL bubble_nop got icode=%h valid=%b valE=%h dst=%h exp 1 0 0 f", bus.m_icode, bus.m_valid, bus.m_valE, bus.m_dstE); end
    total++; if (bus.cc_zf !== 1'b1) begin bad++; $display("FAIL bubble_cc_update got zf=%b exp 1", bus.cc_zf); end
    drive(1, 4'h6, 4'h0, 3'd0, 64'd2, 64'd3, 64'd5, 4'h5);
    step();
    drive(0, 4'h6, 4'h0, 3'd0, 64'd0, 64'd0, 64'd0, 4'h5);
    step();
    total++; if (bus.m_valid !== 1'b0 || bus.m_icode !== 4'h1 || bus.m_dstE !== 4'hF) begin
      bad++; $display("FAIL invalid_nop got valid=%b icode=%h dst=%h exp 0 1 f", bus.m_valid, bus.m_icode, bus.m_dstE); end
    total++; if (bus.cc_zf !== 1'b0) begin bad++; $display("FAIL invalid_cc_hold got zf=%b exp 0", bus.cc_zf); end
  endtask

  task automatic test_cmov();
    drive(1, 4'h6, 4'h0, 3'd0, 64'd1, 64'd2, 64'd3, 4'h1);
    step();
    drive(1, 4'h2, 4'h3, 3'd0, 64'd7, 64'd0, 64'd7, 4'h3);
    total++; if (bus.e_cnd !== 1'b0) begin bad++; $display("FAIL cmov_e_cnd got %b exp 0", bus.e_cnd); end
    step();
`ifdef CC_CMOV_EN
    total++; if (bus.m_dstE !== 4'hF) begin bad++; $display("FAIL cmov_squash got %h exp f", bus.m_dstE); end
`else
    total++; if (bus.m_dstE !== 4'h3) begin bad++; $display("FAIL cmov_pass got %h exp 3", bus.m_dstE); end
`endif
    total++; if (bus.m_cnd !== 1'b0 || bus.m_icode !== 4'h2 || bus.m_valE !== 64'd7) begin
      bad++; $display("FAIL cmov_m got cnd=%b icode=%h valE=%h exp 0 2 7", bus.m_cnd, bus.m_icode, bus.m_valE); end
    drive(1, 4'h2, 4'h4, 3'd0, 64'd8, 64'd0, 64'd8, 4'h3);
    step();
    total++; if (bus.m_dstE !== 4'h3 || bus.m_cnd !== 1'b1) begin bad++; $display("FAIL cmov_taken got dst=%h cnd=%b exp 3 1", bus.m_dstE, bus.m_cnd); end
  endtask

  task automatic test_midstream_reset();
    bus.m_stall = 1;
    rst_n = 0;
    drive(1, 4'h6, 4'h0, 3'd0, 64'd1, 64'd1, 64'h8000_0000_0000_0000, 4'h2);
    step();
    rst_n = 1;
    bus.m_stall = 0;
    total++; if (bus.m_valid !== 1'b0 || bus.m_icode !== 4'h1 || bus.m_dstE !== 4'hF || bus.cc_zf !== 1'b1 || bus.cc_sf !== 1'b0) begin
      bad++; $display("FAIL midreset got valid=%b icode=%h dst=%h zf=%b sf=%b exp 0 1 f 1 0", bus.m_valid, bus.m_icode, bus.m_dstE, bus.cc_zf, bus.cc_sf); end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_flags();
    test_exc_hold();
    test_stall_bubble();
    test_cmov();
    test_midstream_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
